// File: rtl/codec_spi_config_pkg.sv
// Shared definitions for the ADAU1761 SPI configuration block.
// Contents: FSM state encoding, frame constants, init table length,
// ROM entry layout and the SPI frame builder.
package codec_spi_config_pkg;

   localparam logic [7:0]  CHIP_ADDR_W = 8'h00;    // chip address byte, R/W bit = 0 (write)
   localparam logic [15:0] WAIT_ADDR   = 16'hFFFF; // ROM marker for a timed wait entry
   localparam int unsigned INIT_LEN    = 14;
   localparam int unsigned FRAME_BITS  = 32;
   localparam int unsigned IDX_W       = $clog2(INIT_LEN + 1);

   typedef enum logic [2:0] {
      StWake,
      StFetch,
      StWaiting,
      StLoad,
      StShift,
      StEnd,
      StGap,
      StIdle
   } state_e;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } rom_entry_t;

   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [15:0] addr,
                                                        input logic [7:0]  data);
      return {CHIP_ADDR_W, addr, data};
   endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Codec init table: combinational index decode, registered output (1-cycle latency).
// Ports:
//   sys_clk  in   clock
//   idx      in   table index
//   entry    out  {addr[15:0], data[7:0]} of the entry indexed on the previous cycle
module codec_init_rom
   import codec_spi_config_pkg::*;
(
   input  logic             sys_clk,
   input  logic [IDX_W-1:0] idx,
   output rom_entry_t       entry
);

   rom_entry_t entry_d;

   always_comb begin
      entry_d = '{addr: 16'h0000, data: 8'h00};
      case (int'(idx))
         0:  entry_d = '{addr: 16'h4000, data: 8'h01}; // core clock on, MCLK source
         1:  entry_d = '{addr: WAIT_ADDR, data: 8'h00}; // let the core clock settle
         2:  entry_d = '{addr: 16'h4015, data: 8'h00}; // serial port 0: slave
         3:  entry_d = '{addr: 16'h4016, data: 8'h00}; // serial port 1: I2S framing
         4:  entry_d = '{addr: 16'h4017, data: 8'h00}; // converter 0: fs = 48 kHz
         5:  entry_d = '{addr: 16'h401C, data: 8'h21}; // mixer 3: left DAC on
         6:  entry_d = '{addr: 16'h401E, data: 8'h41}; // mixer 4: right DAC on
         7:  entry_d = '{addr: 16'h4023, data: 8'hE7}; // left headphone volume, unmute
         8:  entry_d = '{addr: 16'h4024, data: 8'hE7}; // right headphone volume, unmute
         9:  entry_d = '{addr: 16'h4029, data: 8'h03}; // playback power management
         10: entry_d = '{addr: 16'h402A, data: 8'h03}; // DAC control 0: both channels
         11: entry_d = '{addr: 16'h40F2, data: 8'h01}; // serial input route to DACs
         12: entry_d = '{addr: 16'h40F9, data: 8'h7F}; // clock enable 0
         13: entry_d = '{addr: 16'h40FA, data: 8'h03}; // clock enable 1
         default: entry_d = '{addr: 16'h0000, data: 8'h00};
      endcase
   end

   always_ff @(posedge sys_clk) begin
      entry <= entry_d;
   end

endmodule

// File: rtl/codec_spi_config.sv
// ADAU1761 SPI control-port configurator.
// Wakes the codec into SPI mode (3 CLATCH pulses), replays the init ROM, then accepts
// single-register writes over a valid/ready host port. SPI mode 0, MSB first.
// Ports:
//   sys_clk, rst              clock, synchronous active-high reset
//   host_valid/host_ready     write handshake; host_addr/host_data sampled on handshake
//   busy                      wake, init, frame or gap in progress
//   init_done                 init table complete, sticky until rst
//   ac_clatch/ac_cclk/ac_cdata SPI latch (idle high), clock (idle low), data
module codec_spi_config
   import codec_spi_config_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 5,
   parameter int unsigned GAP         = 2,
   parameter int unsigned WAIT_CYCLES = 100000
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        host_valid,
   output logic        host_ready,
   input  logic [15:0] host_addr,
   input  logic [7:0]  host_data,
   output logic        busy,
   output logic        init_done,
   output logic        ac_clatch,
   output logic        ac_cclk,
   output logic        ac_cdata
);

   localparam int unsigned CNT_W  = $clog2(CLK_DIV + 1);
   localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_CYCLES - 1);
   localparam logic [15:0]       WAKE_LAST  = 16'd5;
   localparam logic [15:0]       SHIFT_LAST = 16'(2 * FRAME_BITS - 1);
   // Latch-high spacing is GAP full CCLK periods, i.e. 2*GAP half-periods.
   localparam logic [15:0]       GAP_LAST   = 16'(2 * GAP - 1);

   state_e                state;
   logic [CNT_W-1:0]      cnt;
   logic [15:0]           half;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [IDX_W-1:0]      idx;
   logic [FRAME_BITS-2:0] shreg;      // bits still to send after the one on ac_cdata
   logic                  host_frame;
   rom_entry_t            rom_entry;
   logic                  tick;
   logic [FRAME_BITS-1:0] rom_word;
   logic [FRAME_BITS-1:0] host_word;

   assign tick      = (cnt == CNT_LAST);
   assign rom_word  = make_frame(rom_entry.addr, rom_entry.data);
   assign host_word = make_frame(host_addr, host_data);

   codec_init_rom u_rom (
      .sys_clk (sys_clk),
      .idx     (idx),
      .entry   (rom_entry)
   );

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state      <= StWake;
         cnt        <= '0;
         half       <= '0;
         wait_cnt   <= '0;
         idx        <= '0;
         shreg      <= '0;
         host_frame <= 1'b0;
         ac_clatch  <= 1'b1;
         ac_cclk    <= 1'b0;
         ac_cdata   <= 1'b0;
         host_ready <= 1'b0;
         busy       <= 1'b0;
         init_done  <= 1'b0;
      end else begin
         // Half-period time base; every transition below happens on a tick or zeroes cnt.
         cnt <= tick ? '0 : cnt + 1'b1;

         case (state)
            StWake: begin
               busy      <= 1'b1;
               // Even half-periods low, odd high: three pulses over six halves.
               ac_clatch <= half[0];
               if (tick) begin
                  if (half == WAKE_LAST) begin
                     half  <= '0;
                     state <= StFetch;
                  end else begin
                     half <= half + 16'd1;
                  end
               end
            end

            StFetch: begin
               // First cycle lets the ROM register the entry for the new idx.
               if (cnt == '0) begin
                  cnt <= CNT_W'(1);
               end else begin
                  cnt <= '0;
                  if (idx == IDX_W'(INIT_LEN)) begin
                     state      <= StIdle;
                     init_done  <= 1'b1;
                     host_ready <= 1'b1;
                     busy       <= 1'b0;
                  end else if (rom_entry.addr == WAIT_ADDR) begin
                     wait_cnt <= '0;
                     state    <= StWaiting;
                  end else begin
                     shreg      <= rom_word[FRAME_BITS-2:0];
                     ac_cdata   <= rom_word[FRAME_BITS-1];
                     ac_clatch  <= 1'b0;
                     host_frame <= 1'b0;
                     state      <= StLoad;
                  end
               end
            end

            StWaiting: begin
               if (wait_cnt == WAIT_LAST) begin
                  idx   <= idx + 1'b1;
                  cnt   <= '0;
                  state <= StFetch;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            StLoad: begin
               if (tick) begin
                  half    <= '0;
                  ac_cclk <= 1'b1;
                  state   <= StShift;
               end
            end

            StShift: begin
               // Even halves are CCLK high; their end is the falling edge where data advances.
               if (tick) begin
                  half <= half + 16'd1;
                  if (!half[0]) begin
                     ac_cclk  <= 1'b0;
                     ac_cdata <= shreg[FRAME_BITS-2];
                     shreg    <= {shreg[FRAME_BITS-3:0], 1'b0};
                  end else if (half == SHIFT_LAST) begin
                     state <= StEnd;
                  end else begin
                     ac_cclk <= 1'b1;
                  end
               end
            end

            StEnd: begin
               if (tick) begin
                  ac_clatch <= 1'b1;
                  half      <= '0;
                  state     <= StGap;
               end
            end

            StGap: begin
               if (tick) begin
                  if (half == GAP_LAST) begin
                     half <= '0;
                     if (host_frame) begin
                        host_ready <= 1'b1;
                        busy       <= 1'b0;
                        state      <= StIdle;
                     end else begin
                        idx   <= idx + 1'b1;
                        state <= StFetch;
                     end
                  end else begin
                     half <= half + 16'd1;
                  end
               end
            end

            StIdle: begin
               if (host_valid && host_ready) begin
                  shreg      <= host_word[FRAME_BITS-2:0];
                  ac_cdata   <= host_word[FRAME_BITS-1];
                  ac_clatch  <= 1'b0;
                  host_ready <= 1'b0;
                  busy       <= 1'b1;
                  host_frame <= 1'b1;
                  cnt        <= '0;
                  state      <= StLoad;
               end
            end

            default: state <= StWake;
         endcase
      end
   end

endmodule

// File: tb/tb_codec_spi_config.sv
`timescale 1ns/1ps
module tb_codec_spi_config;

   localparam int unsigned DIV_A = 5;
   localparam int unsigned GAP_A = 2;
   localparam int unsigned DIV_B = 1;
   localparam int unsigned GAP_B = 1;
   localparam int unsigned WAITC = 50;
   localparam int unsigned NROM  = 13;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int unsigned cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // Unit A: CLK_DIV=5, GAP=2
   logic        rst_a, valid_a, ready_a, busy_a, done_a, lat_a, cclk_a, dat_a;
   logic [15:0] addr_a;
   logic [7:0]  data_a;
   // Unit B: CLK_DIV=1, GAP=1
   logic        rst_b, valid_b, ready_b, busy_b, done_b, lat_b, cclk_b, dat_b;
   logic [15:0] addr_b;
   logic [7:0]  data_b;

   codec_spi_config #(.CLK_DIV(DIV_A), .GAP(GAP_A), .WAIT_CYCLES(WAITC)) dut_a (
      .sys_clk(sys_clk), .rst(rst_a), .host_valid(valid_a), .host_ready(ready_a),
      .host_addr(addr_a), .host_data(data_a), .busy(busy_a), .init_done(done_a),
      .ac_clatch(lat_a), .ac_cclk(cclk_a), .ac_cdata(dat_a)
   );

   codec_spi_config #(.CLK_DIV(DIV_B), .GAP(GAP_B), .WAIT_CYCLES(WAITC)) dut_b (
      .sys_clk(sys_clk), .rst(rst_b), .host_valid(valid_b), .host_ready(ready_b),
      .host_addr(addr_b), .host_data(data_b), .busy(busy_b), .init_done(done_b),
      .ac_clatch(lat_b), .ac_cclk(cclk_b), .ac_cdata(dat_b)
   );

   // Expected init frames (ROM wait entry produces no frame).
   logic [31:0] rom_exp [NROM] = '{
      32'h00400001, 32'h00401500, 32'h00401600, 32'h00401700, 32'h00401C21,
      32'h00401E41, 32'h004023E7, 32'h004024E7, 32'h00402903, 32'h00402A03,
      32'h0040F201, 32'h0040F97F, 32'h0040FA03
   };

   logic [31:0] exp_q0 [$];
   logic [31:0] exp_q1 [$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_rom(input int u);
      for (int i = 0; i < int'(NROM); i++) begin
         if (u == 0) exp_q0.push_back(rom_exp[i]);
         else        exp_q1.push_back(rom_exp[i]);
      end
   endtask

   // ---------------- SPI monitor / scoreboard consumer ----------------
   wire [1:0] rst_w = {rst_b, rst_a};
   wire [1:0] lat_w = {lat_b, lat_a};
   wire [1:0] clk_w = {cclk_b, cclk_a};
   wire [1:0] dat_w = {dat_b, dat_a};

   bit          plat [2], pclk [2], pdat [2], prst [2];
   bit          in_frame [2], glitch [2], hedge [2], perbad [2];
   int unsigned low_cnt [2], high_cnt [2], rises [2], frames [2], wake_cnt [2];
   int unsigned last_rise [2];
   logic [31:0] sh [2];

   task automatic mon_step(input int u);
      int unsigned div;
      int          sz;
      logic [31:0] e;
      div = (u == 0) ? DIV_A : DIV_B;
      if (rst_w[u] || prst[u]) begin
         prst[u]     = rst_w[u];
         in_frame[u] = 1'b0;
         frames[u]   = 0;
         glitch[u]   = 1'b0;
         hedge[u]    = 1'b0;
         high_cnt[u] = 0;
         plat[u] = lat_w[u]; pclk[u] = clk_w[u]; pdat[u] = dat_w[u];
         return;
      end
      if ((dat_w[u] != pdat[u]) && !(pclk[u] && !clk_w[u]) && !(plat[u] && !lat_w[u]))
         glitch[u] = 1'b1;
      if (lat_w[u] && plat[u] && (clk_w[u] != pclk[u]))
         hedge[u] = 1'b1;
      if (plat[u] && !lat_w[u]) begin
         if (frames[u] == 1) begin
            check_eq($sformatf("u%0d_wait_gap", u), 32'(high_cnt[u] >= WAITC), 32'd1);
            check_eq($sformatf("u%0d_wait_cclk", u), 32'(hedge[u]), 32'd0);
         end
         in_frame[u] = 1'b1;
         low_cnt[u]  = 0;
         rises[u]    = 0;
         sh[u]       = '0;
         perbad[u]   = 1'b0;
         high_cnt[u] = 0;
      end
      if (!lat_w[u]) begin
         low_cnt[u]++;
         if (clk_w[u] && !pclk[u]) begin
            sh[u] = {sh[u][30:0], dat_w[u]};
            if ((rises[u] > 0) && (cyc - last_rise[u] != 2 * div)) perbad[u] = 1'b1;
            last_rise[u] = cyc;
            rises[u]++;
         end
      end else begin
         high_cnt[u]++;
      end
      if (!plat[u] && lat_w[u] && in_frame[u]) begin
         in_frame[u] = 1'b0;
         if (rises[u] == 0) begin
            wake_cnt[u]++;
         end else begin
            sz = (u == 0) ? exp_q0.size() : exp_q1.size();
            if (sz == 0) begin
               check_eq($sformatf("u%0d_sb_underflow", u), 32'(sz), 32'd1);
            end else begin
               e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               check_eq($sformatf("u%0d_frame_data", u), sh[u], e);
            end
            check_eq($sformatf("u%0d_frame_bits", u), 32'(rises[u]), 32'd32);
            check_eq($sformatf("u%0d_clatch_low", u), 32'(low_cnt[u]), 32'(66 * div));
            check_eq($sformatf("u%0d_cdata_stable", u), 32'(glitch[u]), 32'd0);
            check_eq($sformatf("u%0d_cclk_period", u), 32'(perbad[u]), 32'd0);
            glitch[u] = 1'b0;
            frames[u]++;
         end
      end
      plat[u] = lat_w[u]; pclk[u] = clk_w[u]; pdat[u] = dat_w[u];
   endtask

   always @(negedge sys_clk) begin
      mon_step(0);
      mon_step(1);
   end

   // ---------------- unit A sequences ----------------
   task automatic wake_check_a();
      logic [29:0] got, exp;
      logic        any_clk, busy0;
      any_clk = 1'b0;
      busy0   = 1'b0;
      @(posedge sys_clk);
      for (int k = 0; k < 30; k++) begin
         @(negedge sys_clk);
         got[k]  = lat_a;
         exp[k]  = (((k / 5) % 2) == 1);
         any_clk = any_clk | cclk_a;
         if (k == 0) busy0 = busy_a;
      end
      check_eq("u0_wake_pattern", 32'(got), 32'(exp));
      check_eq("u0_wake_cclk", 32'(any_clk), 32'd0);
      check_eq("u0_wake_busy", 32'(busy0), 32'd1);
   endtask

   task automatic wait_done_a();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge sys_clk);
         if (done_a) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("u0_init_done", 32'(ok), 32'd1);
      check_eq("u0_sb_drain", 32'(exp_q0.size()), 32'd0);
   endtask

   // Returns the negedge cycle stamp of the handshake cycle.
   task automatic host_write_a(input logic [15:0] a, input logic [7:0] d,
                               output int unsigned t_hs);
      bit ok;
      ok = 1'b0;
      t_hs = 0;
      @(posedge sys_clk); #1;
      valid_a = 1'b1;
      addr_a  = a;
      data_a  = d;
      for (int i = 0; i < 5000; i++) begin
         @(negedge sys_clk);
         if (ready_a) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("u0_hs_ready", 32'(ok), 32'd1);
      exp_q0.push_back({8'h00, a, d});
      t_hs = cyc;
      @(posedge sys_clk); #1;
      valid_a = 1'b0;
      addr_a  = 16'h0000;
      data_a  = 8'h00;
      @(negedge sys_clk);
      check_eq("u0_hs_ready_drop", 32'(ready_a), 32'd0);
      check_eq("u0_hs_clatch_fall", 32'(lat_a), 32'd0);
   endtask

   task automatic seq_a();
      int unsigned t_hs;
      bit          ok;
      @(posedge sys_clk); #1;
      rst_a = 1'b0;
      push_rom(0);
      wake_check_a();
      wait_done_a();

      host_write_a(16'h40F9, 8'h7F, t_hs);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge sys_clk);
         if (ready_a) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("u0_ready_latency", 32'(ok ? (cyc - t_hs) : 0), 32'd351);
      check_eq("u0_host_drain", 32'(exp_q0.size()), 32'd0);

      // Reset in the middle of a host frame.
      host_write_a(16'h4019, 8'h33, t_hs);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge sys_clk);
         if (in_frame[0] && rises[0] >= 12) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("u0_reach_bit12", 32'(ok), 32'd1);
      @(posedge sys_clk); #1;
      rst_a = 1'b1;
      exp_q0.delete();
      @(posedge sys_clk); #1;
      rst_a = 1'b0;
      push_rom(0);
      @(negedge sys_clk);
      check_eq("u0_rst_clatch", 32'(lat_a), 32'd1);
      check_eq("u0_rst_cclk", 32'(cclk_a), 32'd0);
      check_eq("u0_rst_busy", 32'(busy_a), 32'd0);
      check_eq("u0_rst_init_done", 32'(done_a), 32'd0);
      wake_check_a();
      wait_done_a();
   endtask

   // ---------------- unit B sequence ----------------
   task automatic seq_b();
      bit ok;
      @(posedge sys_clk); #1;
      rst_b = 1'b0;
      push_rom(1);
      exp_q1.push_back(32'h004023E7);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge sys_clk);
         if (ready_b) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("u1_ready_seen", 32'(ok), 32'd1);
      check_eq("u1_ready_only_after_init", 32'(done_b), 32'd1);
      check_eq("u1_rom_frames_before_host", 32'(exp_q1.size()), 32'd1);
      @(posedge sys_clk); #1;
      valid_b = 1'b0;
      @(negedge sys_clk);
      check_eq("u1_hs_ready_drop", 32'(ready_b), 32'd0);
      check_eq("u1_hs_clatch_fall", 32'(lat_b), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge sys_clk);
         if (ready_b) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("u1_ready_return", 32'(ok), 32'd1);
      check_eq("u1_sb_drain", 32'(exp_q1.size()), 32'd0);
   endtask

   initial begin
      rst_a   = 1'b1;
      valid_a = 1'b0;
      addr_a  = 16'h0000;
      data_a  = 8'h00;
      rst_b   = 1'b1;
      valid_b = 1'b1;           // held from reset release
      addr_b  = 16'h4023;
      data_b  = 8'hE7;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check_eq("u0_reset_clatch", 32'(lat_a), 32'd1);
      check_eq("u0_reset_cclk", 32'(cclk_a), 32'd0);
      check_eq("u0_reset_cdata", 32'(dat_a), 32'd0);
      check_eq("u0_reset_ready", 32'(ready_a), 32'd0);
      check_eq("u0_reset_busy", 32'(busy_a), 32'd0);
      check_eq("u0_reset_init_done", 32'(done_a), 32'd0);
      check_eq("u1_reset_ready", 32'(ready_b), 32'd0);

      fork
         seq_a();
         seq_b();
      join

      repeat (5) @(negedge sys_clk);
      check_eq("u0_wake_pulses", 32'(wake_cnt[0]), 32'd6);
      check_eq("u1_wake_pulses", 32'(wake_cnt[1]), 32'd3);
      check_eq("u0_idle_cclk", 32'(hedge[0]), 32'd0);
      check_eq("u1_idle_cclk", 32'(hedge[1]), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
